// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch stage's instruction-memory port and its issue port to the decode/control stage.
// master = fetch unit, slave = memory plus decode environment.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        accept;
    logic        PCSrc;
    logic [31:0] imm_ext;
    logic        misaligned;

    modport master (
        output imem_req, imem_addr, instr, op, pc, pc_plus4, instr_valid, misaligned,
        input  imem_rdata, imem_valid, accept, PCSrc, imm_ext
    );

    modport slave (
        input  imem_req, imem_addr, instr, op, pc, pc_plus4, instr_valid, misaligned,
        output imem_rdata, imem_valid, accept, PCSrc, imm_ext
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC and instruction-fetch stage: fetches one word per instruction, issues it downstream,
// and redirects the PC on accept; a misaligned taken branch halts the stage until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_misaligned;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_misaligned_nxt;
    logic [31:0] w_target;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; rst is checked first so it overrides any in-flight handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_instr      <= NOP;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    assign w_target = bus.PCSrc ? (r_pc + bus.imm_ext) : (r_pc + 32'd4);

    // NOTE: every signal gets a hold-value default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_instr_nxt      = r_instr;
        w_misaligned_nxt = r_misaligned;
        unique case (r_state)
            S_FETCH: begin
                if (bus.imem_valid) begin
                    w_instr_nxt = bus.imem_rdata;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.accept) begin
                    if (bus.PCSrc && (w_target[1:0] != 2'b00)) begin
                        w_misaligned_nxt = 1'b1;
                        w_state_nxt      = S_HALT;
                    end else begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Handshake outputs decode registered state only, never the inputs.
    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.instr_valid = (r_state == S_ISSUE);
    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = r_pc + 32'd4;
    assign bus.instr       = r_instr;
    assign bus.op          = r_instr[6:0];
    assign bus.misaligned  = r_misaligned;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, wait states, stalls, branches, wrap-around,
// misaligned halt and reset priority, with hand-computed expected values.
module tb_instr_fetch_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch with zero wait states; leaves the unit in ISSUE.
    task automatic fetch(input logic [31:0] word);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    // One accepted issue cycle with the given branch decision.
    task automatic issue(input logic pcsrc, input logic [31:0] imm);
        bus.accept  = 1'b1;
        bus.PCSrc   = pcsrc;
        bus.imm_ext = imm;
        tick();
        bus.accept  = 1'b0;
        bus.PCSrc   = 1'b0;
        bus.imm_ext = 32'h0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc"},          bus.pc,          32'h0000_0000);
        check({tag, ".addr"},        bus.imem_addr,   32'h0000_0000);
        check({tag, ".instr"},       bus.instr,       32'h0000_0013);
        check({tag, ".op"},          {25'h0, bus.op}, 32'h0000_0013);
        check({tag, ".instr_valid"}, {31'h0, bus.instr_valid}, 32'h0);
        check({tag, ".imem_req"},    {31'h0, bus.imem_req},    32'h1);
        check({tag, ".misaligned"},  {31'h0, bus.misaligned},  32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.accept     = 1'b0;
        bus.PCSrc      = 1'b0;
        bus.imm_ext    = 32'h0;

        tick();
        check_reset_state("reset");
        check("reset.pc_plus4", bus.pc_plus4, 32'h0000_0004);

        // Zero-wait lw at 0x0 with accept held high.
        rst            = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'h0000_0003;
        bus.accept     = 1'b1;
        tick();
        bus.imem_valid = 1'b0;
        check("lw.op",          {25'h0, bus.op}, 32'h0000_0003);
        check("lw.pc",          bus.pc,          32'h0000_0000);
        check("lw.pc_plus4",    bus.pc_plus4,    32'h0000_0004);
        check("lw.instr_valid", {31'h0, bus.instr_valid}, 32'h1);
        check("lw.imem_req",    {31'h0, bus.imem_req},    32'h0);
        tick();
        bus.accept = 1'b0;
        check("lw.next_addr",   bus.imem_addr,   32'h0000_0004);
        check("lw.next_req",    {31'h0, bus.imem_req},    32'h1);

        // Three memory wait cycles; request and address held.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait.imem_req",    {31'h0, bus.imem_req},    32'h1);
            check("wait.addr",        bus.imem_addr,            32'h0000_0004);
            check("wait.instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        end
        fetch(32'h00A0_0093);
        check("wait.instr", bus.instr, 32'h00A0_0093);

        // Accept delayed two cycles; stray imem_valid/PCSrc must be ignored.
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.PCSrc      = 1'b1;
        bus.imm_ext    = 32'h0000_0100;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall.instr_valid", {31'h0, bus.instr_valid}, 32'h1);
            check("stall.instr",       bus.instr,                32'h00A0_0093);
            check("stall.pc",          bus.pc,                   32'h0000_0004);
        end
        bus.imem_valid = 1'b0;
        issue(1'b0, 32'h0);
        check("stall.next_addr", bus.imem_addr, 32'h0000_0008);

        // Taken beq at 0x10 with offset -8.
        fetch(32'h0000_0013); issue(1'b0, 32'h0);
        fetch(32'h0000_0013); issue(1'b0, 32'h0);
        fetch(32'h0000_0063);
        check("beq.pc", bus.pc,          32'h0000_0010);
        check("beq.op", {25'h0, bus.op}, 32'h0000_0063);
        issue(1'b1, 32'hFFFF_FFF8);
        check("beq_taken.addr", bus.imem_addr, 32'h0000_0008);

        // Same beq not taken.
        fetch(32'h0000_0013); issue(1'b0, 32'h0);
        fetch(32'h0000_0013); issue(1'b0, 32'h0);
        fetch(32'h0000_0063);
        issue(1'b0, 32'hFFFF_FFF8);
        check("beq_not_taken.addr", bus.imem_addr, 32'h0000_0014);

        // Jump to 0xFFFFFFFC, then sequential wrap to 0.
        fetch(32'h0000_0063);
        issue(1'b1, 32'hFFFF_FFE8);
        check("wrap.addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        check("wrap.pc_plus4", bus.pc_plus4, 32'h0000_0000);
        issue(1'b0, 32'h0);
        check("wrap.pc",         bus.pc,                  32'h0000_0000);
        check("wrap.misaligned", {31'h0, bus.misaligned}, 32'h0);
        check("wrap.imem_req",   {31'h0, bus.imem_req},   32'h1);

        // Misaligned taken branch from 0x20 halts the stage.
        fetch(32'h0000_0063); issue(1'b1, 32'h0000_0020);
        check("halt.pre_pc", bus.pc, 32'h0000_0020);
        fetch(32'h0000_0063); issue(1'b1, 32'h0000_0006);
        check("halt.misaligned",  {31'h0, bus.misaligned},  32'h1);
        check("halt.imem_req",    {31'h0, bus.imem_req},    32'h0);
        check("halt.instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("halt.pc",          bus.pc,                   32'h0000_0020);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'h0000_0003;
        bus.accept     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt.hold_misaligned", {31'h0, bus.misaligned}, 32'h1);
            check("halt.hold_req",        {31'h0, bus.imem_req},   32'h0);
            check("halt.hold_pc",         bus.pc,                  32'h0000_0020);
        end
        bus.imem_valid = 1'b0;
        bus.accept     = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("halt_rst");

        // Reset in FETCH with imem_valid high.
        fetch(32'h0000_0063); issue(1'b1, 32'h0000_0040);
        check("rst_fetch.pre_pc", bus.pc, 32'h0000_0040);
        rst            = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'h0000_0003;
        tick();
        rst            = 1'b0;
        bus.imem_valid = 1'b0;
        check_reset_state("rst_fetch");

        // Reset in ISSUE with a taken accept.
        fetch(32'h0000_0063); issue(1'b1, 32'h0000_0040);
        fetch(32'h0000_0003);
        check("rst_issue.pre_valid", {31'h0, bus.instr_valid}, 32'h1);
        rst         = 1'b1;
        bus.accept  = 1'b1;
        bus.PCSrc   = 1'b1;
        bus.imm_ext = 32'h0000_0100;
        tick();
        rst         = 1'b0;
        bus.accept  = 1'b0;
        bus.PCSrc   = 1'b0;
        bus.imm_ext = 32'h0;
        check_reset_state("rst_issue");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and instruction-fetch stage of the RISC-V core, directly upstream of the main decoder. Holds the PC, requests one 32-bit word per instruction from instruction memory over a valid/request handshake, and presents the fetched instruction and its opcode field to the decode/control stage. Updates the PC from the decoder's PCSrc and the extended immediate when the downstream stage accepts the instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction-memory read request; high only in FETCH.
- imem_addr  output  32  read address; equals pc.
- imem_rdata  input  32  instruction word; valid when imem_valid is high.
- imem_valid  input  1  memory response strobe; honoured only in FETCH.
- instr  output  32  registered instruction word.
- op  output  7  instr[6:0], feeds the main decoder's op input.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- instr_valid  output  1  high in ISSUE; instr/op/pc are stable.
- accept  input  1  downstream consumed the instruction this cycle.
- PCSrc  input  1  1 = branch taken; sampled only with accept.
- imm_ext  input  32  sign-extended branch offset; sampled only with accept.
- misaligned  output  1  sticky fault: a taken branch targeted a non-word-aligned address.

## Operation
- States: FETCH, ISSUE, HALT. Reset state FETCH.
- Reset values: pc = RESET_PC, instr = 32'h0000_0013 (NOP, addi x0,x0,0), instr_valid = 0, misaligned = 0, imem_req = 1 (state FETCH).
- FETCH: imem_req = 1, imem_addr = pc. On imem_valid: instr <= imem_rdata, go ISSUE. Without imem_valid: stay, hold address and request.
- ISSUE: instr_valid = 1, imem_req = 0. Without accept: stay; instr, pc and outputs held unchanged. On accept:
  - next_pc = PCSrc ? pc + imm_ext : pc + 4 (32-bit add, carry discarded, wrap-around allowed).
  - If PCSrc = 1 and next_pc[1:0] != 0: pc unchanged, misaligned <= 1, go HALT.
  - Else pc <= next_pc, go FETCH.
- HALT: imem_req = 0, instr_valid = 0; remains until rst. misaligned stays 1.
- imem_valid outside FETCH is ignored; no instruction is captured.
- PCSrc and imm_ext ignored in any cycle without accept in ISSUE.
- rst has priority over every other input in every state, including mid-fetch with imem_valid high and mid-issue with accept high; the in-flight instruction is dropped.

## Timing
- Minimum loop: 2 cycles per instruction (FETCH with same-cycle imem_valid, then ISSUE with same-cycle accept).
- Each memory wait cycle adds 1 cycle in FETCH; each cycle without accept adds 1 cycle in ISSUE.
- imem_req and instr_valid are decoded from registered state only; never combinational from inputs.
- instr_valid rises the cycle after imem_valid is sampled high.
- New pc visible on imem_addr the cycle after accept.
- First imem_req high in the first cycle rst is low (and during reset, address RESET_PC).
- op always equals instr[6:0], including while instr_valid = 0.

## Test plan
- Reset, zero-wait memory returning 0x00000003 (lw) at 0x0, accept held high -> after 2 cycles op = 7'b0000011, pc = 0; next imem_addr = 0x4; pc_plus4 = 0x4.
- Memory with 3 wait cycles, accept delayed 2 cycles -> imem_req high for 4 cycles, instr_valid high for 3 cycles, pc/instr unchanged throughout.
- beq at pc 0x10, accept with PCSrc = 1, imm_ext = 0xFFFFFFF8 -> next imem_addr = 0x08; with PCSrc = 0 -> 0x14.
- pc = 0xFFFFFFFC, accept with PCSrc = 0 -> pc wraps to 0x00000000, no fault.
- Taken branch with imm_ext = 0x6 from pc 0x20 -> misaligned = 1, state HALT, imem_req = 0, pc = 0x20; stays until rst, then pc = RESET_PC, misaligned = 0.
- rst asserted in FETCH with imem_valid high, and again in ISSUE with accept high -> next cycle pc = RESET_PC, instr = 0x00000013, instr_valid = 0, imem_req = 1.
